// File: rtl/pipe_reg_hs.sv
// rtl/pipe_reg_hs.sv - valid/ready pipeline stage register with flush and optional skid entry
// Head payload comes straight from r_main; with SKID=1 a second entry lets in_ready be a flop.
module pipe_reg_hs #(
  parameter int unsigned      WIDTH     = 32,
  parameter bit               SKID      = 1'b1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  // Encoding equals the number of held entries, so count is the state itself.
  typedef enum logic [1:0] {
    ST_EMPTY    = 2'd0,
    ST_FULL     = 2'd1,
    ST_SKIDFULL = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;
  logic [WIDTH-1:0] w_main_nxt;
  logic [WIDTH-1:0] w_skid_nxt;
  logic             w_ix;
  logic             w_ox;

  assign w_ix      = in_valid & in_ready;
  assign w_ox      = out_valid & out_ready;
  assign out_valid = (r_state != ST_EMPTY);
  assign out_data  = r_main;
  assign count     = r_state;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_EMPTY;
      r_main  <= RESET_VAL;
      r_skid  <= RESET_VAL;
    end else begin
      r_state <= w_state_nxt;
      r_main  <= w_main_nxt;
      r_skid  <= w_skid_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;
    if (flush) begin
      // An output transfer in this cycle has already been sampled downstream.
      w_state_nxt = ST_EMPTY;
      w_main_nxt  = RESET_VAL;
      w_skid_nxt  = RESET_VAL;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_ix) begin
            w_state_nxt = ST_FULL;
            w_main_nxt  = in_data;
          end
        end
        ST_FULL: begin
          if (w_ix && w_ox) begin
            w_main_nxt = in_data;
          end else if (w_ox) begin
            w_state_nxt = ST_EMPTY;
          end else if (w_ix && SKID) begin
            w_state_nxt = ST_SKIDFULL;
            w_skid_nxt  = in_data;
          end
        end
        ST_SKIDFULL: begin
          if (w_ox) begin
            w_state_nxt = ST_FULL;
            w_main_nxt  = r_skid;
          end
        end
        default: begin
          w_state_nxt = ST_EMPTY;
        end
      endcase
    end
  end

  generate
    if (SKID) begin : g_skid
      logic r_in_ready;
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          r_in_ready <= 1'b1;
        end else begin
          r_in_ready <= (w_state_nxt != ST_SKIDFULL);
        end
      end
      assign in_ready = r_in_ready;
    end else begin : g_noskid
      assign in_ready = ~out_valid | out_ready;
    end
  endgenerate

endmodule

// File: tb/tb_pipe_reg_hs.sv
// tb/tb_pipe_reg_hs.sv - self-checking bench for pipe_reg_hs, SKID=1 and SKID=0 side by side
// Per-DUT FIFO scoreboards push on input transfers and pop/compare on output transfers.
module tb_pipe_reg_hs;

  localparam int unsigned      W  = 16;
  localparam logic [W-1:0]     RV = 16'h5A5A;

  logic         clk;
  logic         resetn;
  logic         s_flush, s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [W-1:0] s_in_data, s_out_data;
  logic [1:0]   s_count;
  logic         n_flush, n_in_valid, n_in_ready, n_out_valid, n_out_ready;
  logic [W-1:0] n_in_data, n_out_data;
  logic [1:0]   n_count;

  int errors;
  int checks;
  logic [W-1:0] s_q[$];
  logic [W-1:0] n_q[$];

  pipe_reg_hs #(.WIDTH(W), .SKID(1'b1), .RESET_VAL(RV)) u_skid (
    .clk(clk), .resetn(resetn), .flush(s_flush),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
    .count(s_count)
  );

  pipe_reg_hs #(.WIDTH(W), .SKID(1'b0), .RESET_VAL(RV)) u_noskid (
    .clk(clk), .resetn(resetn), .flush(n_flush),
    .in_valid(n_in_valid), .in_ready(n_in_ready), .in_data(n_in_data),
    .out_valid(n_out_valid), .out_ready(n_out_ready), .out_data(n_out_data),
    .count(n_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    logic [W-1:0] exp_d;
    if (!resetn) begin
      s_q.delete();
    end else begin
      if (s_out_valid && s_out_ready) begin
        checks++;
        if (s_q.size() == 0) begin
          errors++;
          $display("FAIL sb_skid_underflow got=%0h exp=none", s_out_data);
        end else begin
          exp_d = s_q.pop_front();
          if (s_out_data !== exp_d) begin
            errors++;
            $display("FAIL sb_skid_data got=%0h exp=%0h", s_out_data, exp_d);
          end
        end
      end
      if (s_flush) s_q.delete();
      else if (s_in_valid && s_in_ready) s_q.push_back(s_in_data);
    end
  end

  always @(negedge clk) begin
    logic [W-1:0] exp_d;
    if (!resetn) begin
      n_q.delete();
    end else begin
      if (n_out_valid && n_out_ready) begin
        checks++;
        if (n_q.size() == 0) begin
          errors++;
          $display("FAIL sb_noskid_underflow got=%0h exp=none", n_out_data);
        end else begin
          exp_d = n_q.pop_front();
          if (n_out_data !== exp_d) begin
            errors++;
            $display("FAIL sb_noskid_data got=%0h exp=%0h", n_out_data, exp_d);
          end
        end
      end
      if (n_flush) n_q.delete();
      else if (n_in_valid && n_in_ready) n_q.push_back(n_in_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    s_flush = 0; s_in_valid = 0; s_out_ready = 0; s_in_data = '0;
    n_flush = 0; n_in_valid = 0; n_out_ready = 0; n_in_data = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    resetn = 1'b0;
    tick(); tick();
    checks++; if (s_out_valid !== 1'b0) begin errors++; $display("FAIL rst_skid_valid got=%0b exp=0", s_out_valid); end
    checks++; if (s_count !== 2'd0) begin errors++; $display("FAIL rst_skid_count got=%0d exp=0", s_count); end
    checks++; if (s_out_data !== RV) begin errors++; $display("FAIL rst_skid_data got=%0h exp=%0h", s_out_data, RV); end
    checks++; if (s_in_ready !== 1'b1) begin errors++; $display("FAIL rst_skid_ready got=%0b exp=1", s_in_ready); end
    checks++; if (n_out_valid !== 1'b0) begin errors++; $display("FAIL rst_noskid_valid got=%0b exp=0", n_out_valid); end
    checks++; if (n_count !== 2'd0) begin errors++; $display("FAIL rst_noskid_count got=%0d exp=0", n_count); end
    checks++; if (n_out_data !== RV) begin errors++; $display("FAIL rst_noskid_data got=%0h exp=%0h", n_out_data, RV); end
    checks++; if (n_in_ready !== 1'b1) begin errors++; $display("FAIL rst_noskid_ready got=%0b exp=1", n_in_ready); end
    resetn = 1'b1;
    tick();
    s_in_valid = 1; s_in_data = 16'h1111; tick();
    s_in_data = 16'h2222; tick();
    s_in_valid = 0;
    checks++; if (s_count !== 2'd2) begin errors++; $display("FAIL rst_pre_count got=%0d exp=2", s_count); end
    #2 resetn = 1'b0;
    #1;
    checks++; if (s_out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got=%0b exp=0", s_out_valid); end
    checks++; if (s_count !== 2'd0) begin errors++; $display("FAIL rst_mid_count got=%0d exp=0", s_count); end
    checks++; if (s_out_data !== RV) begin errors++; $display("FAIL rst_mid_data got=%0h exp=%0h", s_out_data, RV); end
    checks++; if (s_in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready got=%0b exp=1", s_in_ready); end
    tick();
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_streaming();
    idle_inputs();
    s_out_ready = 1; n_out_ready = 1;
    s_in_valid = 1;  n_in_valid = 1;
    for (int k = 1; k <= 4; k++) begin
      s_in_data = W'(k); n_in_data = W'(k);
      tick();
      checks++; if (s_out_data !== W'(k)) begin errors++; $display("FAIL stream_skid_data got=%0h exp=%0h", s_out_data, k); end
      checks++; if (s_count !== 2'd1) begin errors++; $display("FAIL stream_skid_count got=%0d exp=1", s_count); end
      checks++; if (s_in_ready !== 1'b1) begin errors++; $display("FAIL stream_skid_ready got=%0b exp=1", s_in_ready); end
      checks++; if (n_out_data !== W'(k)) begin errors++; $display("FAIL stream_noskid_data got=%0h exp=%0h", n_out_data, k); end
      checks++; if (n_count !== 2'd1) begin errors++; $display("FAIL stream_noskid_count got=%0d exp=1", n_count); end
    end
    s_in_valid = 0; n_in_valid = 0;
    tick();
    checks++; if (s_count !== 2'd0) begin errors++; $display("FAIL stream_skid_drain got=%0d exp=0", s_count); end
    checks++; if (n_count !== 2'd0) begin errors++; $display("FAIL stream_noskid_drain got=%0d exp=0", n_count); end
  endtask

  task automatic test_backpressure_skid();
    idle_inputs();
    s_in_valid = 1; s_in_data = 16'h000A;
    tick();
    checks++; if (s_in_ready !== 1'b1) begin errors++; $display("FAIL bp_skid_ready_full got=%0b exp=1", s_in_ready); end
    s_in_data = 16'h000B;
    tick();
    s_in_valid = 1; s_in_data = 16'h00EE;
    checks++; if (s_count !== 2'd2) begin errors++; $display("FAIL bp_skid_count got=%0d exp=2", s_count); end
    checks++; if (s_in_ready !== 1'b0) begin errors++; $display("FAIL bp_skid_ready got=%0b exp=0", s_in_ready); end
    checks++; if (s_out_data !== 16'h000A) begin errors++; $display("FAIL bp_skid_head got=%0h exp=a", s_out_data); end
    tick();
    s_in_valid = 0;
    checks++; if (s_out_data !== 16'h000A) begin errors++; $display("FAIL bp_skid_hold got=%0h exp=a", s_out_data); end
    s_out_ready = 1;
    #1;
    checks++; if (s_in_ready !== 1'b0) begin errors++; $display("FAIL bp_skid_ready_reg got=%0b exp=0", s_in_ready); end
    tick();
    checks++; if (s_out_data !== 16'h000B) begin errors++; $display("FAIL bp_skid_second got=%0h exp=b", s_out_data); end
    checks++; if (s_count !== 2'd1) begin errors++; $display("FAIL bp_skid_count1 got=%0d exp=1", s_count); end
    checks++; if (s_in_ready !== 1'b1) begin errors++; $display("FAIL bp_skid_ready_back got=%0b exp=1", s_in_ready); end
    tick();
    checks++; if (s_count !== 2'd0) begin errors++; $display("FAIL bp_skid_empty got=%0d exp=0", s_count); end
  endtask

  task automatic test_backpressure_noskid();
    idle_inputs();
    n_in_valid = 1; n_in_data = 16'h0031;
    tick();
    n_in_data = 16'h000C;
    #1;
    checks++; if (n_in_ready !== 1'b0) begin errors++; $display("FAIL bp_noskid_ready got=%0b exp=0", n_in_ready); end
    tick(); tick();
    checks++; if (n_out_data !== 16'h0031) begin errors++; $display("FAIL bp_noskid_hold got=%0h exp=31", n_out_data); end
    checks++; if (n_count !== 2'd1) begin errors++; $display("FAIL bp_noskid_count got=%0d exp=1", n_count); end
    n_out_ready = 1;
    #1;
    checks++; if (n_in_ready !== 1'b1) begin errors++; $display("FAIL bp_noskid_ready_comb got=%0b exp=1", n_in_ready); end
    tick();
    n_in_valid = 0;
    checks++; if (n_out_data !== 16'h000C) begin errors++; $display("FAIL bp_noskid_accept got=%0h exp=c", n_out_data); end
    tick();
    checks++; if (n_count !== 2'd0) begin errors++; $display("FAIL bp_noskid_empty got=%0d exp=0", n_count); end
  endtask

  task automatic test_flush();
    idle_inputs();
    s_in_valid = 1; s_in_data = 16'h0011; tick();
    s_in_data = 16'h0022; tick();
    checks++; if (s_count !== 2'd2) begin errors++; $display("FAIL flush_pre_count got=%0d exp=2", s_count); end
    s_flush = 1; s_in_data = 16'h000D;
    tick();
    s_flush = 0; s_in_valid = 0;
    checks++; if (s_count !== 2'd0) begin errors++; $display("FAIL flush_skid_count got=%0d exp=0", s_count); end
    checks++; if (s_out_valid !== 1'b0) begin errors++; $display("FAIL flush_skid_valid got=%0b exp=0", s_out_valid); end
    checks++; if (s_out_data !== RV) begin errors++; $display("FAIL flush_skid_data got=%0h exp=%0h", s_out_data, RV); end
    checks++; if (s_in_ready !== 1'b1) begin errors++; $display("FAIL flush_skid_ready got=%0b exp=1", s_in_ready); end
    s_out_ready = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (s_out_valid !== 1'b0) begin errors++; $display("FAIL flush_skid_ghost got=%0b data=%0h exp=0", s_out_valid, s_out_data); end
    end
    n_in_valid = 1; n_in_data = 16'h0041; tick();
    n_flush = 1; n_out_ready = 1; n_in_data = 16'h0042;
    tick();
    n_flush = 0; n_in_valid = 0;
    checks++; if (n_count !== 2'd0) begin errors++; $display("FAIL flush_noskid_count got=%0d exp=0", n_count); end
    checks++; if (n_out_valid !== 1'b0) begin errors++; $display("FAIL flush_noskid_valid got=%0b exp=0", n_out_valid); end
    checks++; if (n_out_data !== RV) begin errors++; $display("FAIL flush_noskid_data got=%0h exp=%0h", n_out_data, RV); end
    tick();
  endtask

  task automatic test_random();
    logic         s_pv, s_pr, s_pf, n_pv, n_pr, n_pf;
    logic [W-1:0] s_pd, n_pd;
    idle_inputs();
    for (int i = 0; i < 10000; i++) begin
      s_in_valid  = 1'($urandom_range(0, 1));
      s_out_ready = 1'($urandom_range(0, 1));
      s_flush     = ($urandom_range(0, 63) == 0);
      s_in_data   = W'($urandom);
      n_in_valid  = 1'($urandom_range(0, 1));
      n_out_ready = 1'($urandom_range(0, 1));
      n_flush     = ($urandom_range(0, 63) == 0);
      n_in_data   = W'($urandom);
      s_pv = s_out_valid; s_pr = s_out_ready; s_pf = s_flush; s_pd = s_out_data;
      n_pv = n_out_valid; n_pr = n_out_ready; n_pf = n_flush; n_pd = n_out_data;
      tick();
      checks++; if (s_count > 2'd2) begin errors++; $display("FAIL rnd_skid_count got=%0d exp<=2", s_count); end
      checks++; if (n_count > 2'd1) begin errors++; $display("FAIL rnd_noskid_count got=%0d exp<=1", n_count); end
      if (s_pv && !s_pr && !s_pf) begin
        checks++;
        if (s_out_valid !== 1'b1 || s_out_data !== s_pd) begin
          errors++; $display("FAIL rnd_skid_stall got=%0b/%0h exp=1/%0h", s_out_valid, s_out_data, s_pd);
        end
      end
      if (n_pv && !n_pr && !n_pf) begin
        checks++;
        if (n_out_valid !== 1'b1 || n_out_data !== n_pd) begin
          errors++; $display("FAIL rnd_noskid_stall got=%0b/%0h exp=1/%0h", n_out_valid, n_out_data, n_pd);
        end
      end
    end
    idle_inputs();
    s_out_ready = 1; n_out_ready = 1;
    repeat (4) tick();
    checks++; if (s_q.size() != 0 || s_out_valid !== 1'b0) begin errors++; $display("FAIL rnd_skid_leftover got=%0d exp=0", s_q.size()); end
    checks++; if (n_q.size() != 0 || n_out_valid !== 1'b0) begin errors++; $display("FAIL rnd_noskid_leftover got=%0d exp=0", n_q.size()); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    resetn = 1'b0;
    idle_inputs();
    test_reset();
    test_streaming();
    test_backpressure_skid();
    test_backpressure_noskid();
    test_flush();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
